// File: rtl/adder_nibble_serial_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package adder_nibble_serial_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_nibble_serial_cla4.sv
// 4-bit carry-lookahead adder slice; purely combinational.
module adder_nibble_serial_cla4
  import adder_nibble_serial_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                ci_i,
  output logic [NIBBLE_W-1:0] s_o,
  output logic                co_o
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is flattened to generate/propagate terms of ci, none ripple.
  assign c[0] = ci_i;
  assign c[1] = g[0] | (p[0] & ci_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci_i);

  assign s_o  = p ^ c[NIBBLE_W-1:0];
  assign co_o = c[NIBBLE_W];

endmodule

// File: rtl/adder_nibble_serial.sv
// WIDTH-bit add/subtract that time-multiplexes one 4-bit CLA slice, one nibble per
// cycle LSB-first, with valid/ready handshakes on operand and result sides.
module adder_nibble_serial
  import adder_nibble_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int CW  = $clog2(NIB);
  localparam logic [CW-1:0] LAST_IDX = CW'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("adder_nibble_serial: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t            state_q, state_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] slice_a;
  logic [NIBBLE_W-1:0] slice_b;
  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;

  assign slice_a = a_q[NIBBLE_W*idx_q +: NIBBLE_W];
  assign slice_b = b_q[NIBBLE_W*idx_q +: NIBBLE_W];

  adder_nibble_serial_cla4 u_slice (
    .a_i  (slice_a),
    .b_i  (slice_b),
    .ci_i (carry_q),
    .s_o  (slice_s),
    .co_o (slice_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1, so B is stored already inverted.
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub | in_cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[NIBBLE_W*idx_q +: NIBBLE_W] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[NIBBLE_W-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Latched operands are only read in RUN, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_nibble_serial.sv
// Bench for adder_nibble_serial: fixed vector table, randomized ops against an
// arithmetic model, and hand sequences for backpressure, reset and WIDTH=8.
module tb_adder_nibble_serial;

  localparam int NIB = 8;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_sub = 1'b0, in_cin = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_sum;
  logic        out_cout, out_ovf;

  logic        in_valid8 = 1'b0, in_ready8;
  logic [7:0]  in_a8 = '0, in_b8 = '0;
  logic        in_sub8 = 1'b0, in_cin8 = 1'b0;
  logic        out_valid8, out_ready8 = 1'b1;
  logic [7:0]  out_sum8;
  logic        out_cout8, out_ovf8;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  adder_nibble_serial #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  adder_nibble_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8),
    .in_sub(in_sub8), .in_cin(in_cin8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_sum(out_sum8),
    .out_cout(out_cout8), .out_ovf(out_ovf8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: unsigned sum for result/carry, wide signed sum for overflow.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic sub, input logic cin,
                                output logic [31:0] s, output logic co, output logic ov);
    logic [32:0] u;
    longint sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      u  = {1'b0, a} - {1'b0, b};
      co = (a >= b);
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      co = u[32];
      sr = sa + sb + (cin ? 64'sd1 : 64'sd0);
    end
    s  = u[31:0];
    ov = (sr > SMAX) || (sr < SMIN);
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic cin, output logic [31:0] s, output logic co,
                       output logic ov, output int lat, output int acc);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom); in_cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    s = out_sum; co = out_cout; ov = out_ovf;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t        vecs[10];
  logic [31:0] s, es, held;
  logic        co, ov, eco, eov;
  int          lat, acc, prev_acc;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0,         1'b1, 1'b0};
    vecs[1] = '{32'h5,         32'h7,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h7,         32'h5,         1'b1, 1'b0, 32'h2,         1'b1, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'h8000_0000, 32'h1,         1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h3,         32'h4,         1'b0, 1'b0, 32'h7,         1'b0, 1'b0};
    vecs[6] = '{32'hA000_0000, 32'hA000_0000, 1'b0, 1'b0, 32'h4000_0000, 1'b1, 1'b1};
    vecs[7] = '{32'h0000_000F, 32'h0,         1'b0, 1'b1, 32'h10,        1'b0, 1'b0};
    vecs[8] = '{32'hA,         32'h3,         1'b1, 1'b1, 32'h7,         1'b1, 1'b0};
    vecs[9] = '{32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rstn = 1'b1;

    // Fixed vectors issued back-to-back; accept spacing must be NIB+2.
    prev_acc = 0;
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, s, co, ov, lat, acc);
      chk($sformatf("vec%0d_lat", i), lat, NIB);
      chk($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      chk($sformatf("vec%0d_cout", i), co, vecs[i].cout);
      chk($sformatf("vec%0d_ovf", i), ov, vecs[i].ovf);
      if (i > 0) chk($sformatf("vec%0d_spacing", i), acc - prev_acc, NIB + 2);
      prev_acc = acc;
    end

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic rs, rc;
      ra = $urandom; rb = $urandom; rs = 1'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) rb = ~ra;
      model(ra, rb, rs, rc, es, eco, eov);
      do_op(ra, rb, rs, rc, s, co, ov, lat, acc);
      chk($sformatf("rnd%0d_sum", i), s, es);
      chk($sformatf("rnd%0d_cout", i), co, eco);
      chk($sformatf("rnd%0d_ovf", i), ov, eov);
    end

    // Backpressure: result must hold and new operands must be refused.
    out_ready = 1'b0;
    @(negedge clk);
    in_a = 32'h0000_1234; in_b = 32'h0000_0100; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", lat, NIB);
    held = out_sum;
    chk("bp_sum", held, 32'h0000_1334);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = 1'($urandom);
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", i), out_valid, 1);
      chk($sformatf("bp%0d_sum", i), out_sum, 32'h0000_1334);
      chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_pop_valid", out_valid, 0);
    chk("bp_pop_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("bp_no_ghost_valid", out_valid, 0);
    chk("bp_no_ghost_in_ready", in_ready, 1);

    // Reset while idx=3 aborts the op.
    @(negedge clk);
    in_a = 32'h1234_5678; in_b = 32'h1111_1111; in_sub = 1'b0; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_out_cout", out_cout, 0);
    chk("midrst_out_ovf", out_ovf, 0);
    rstn = 1'b1;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, s, co, ov, lat, acc);
    chk("postrst_lat", lat, NIB);
    chk("postrst_sum", s, 32'h2345_6789);
    chk("postrst_cout", co, 0);

    // WIDTH=8 instance: two nibbles, latency 2.
    @(negedge clk);
    in_a8 = 8'hF0; in_b8 = 8'h10; in_sub8 = 1'b0; in_cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_lat", lat, 2);
    chk("w8_sum", out_sum8, 8'h00);
    chk("w8_cout", out_cout8, 1);
    chk("w8_ovf", out_ovf8, 0);
    @(posedge clk); #1;
    chk("w8_pop_in_ready", in_ready8, 1);
    @(negedge clk);
    in_a8 = 8'h80; in_b8 = 8'h01; in_sub8 = 1'b1; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_sub_lat", lat, 2);
    chk("w8_sub_sum", out_sum8, 8'h7F);
    chk("w8_sub_cout", out_cout8, 1);
    chk("w8_sub_ovf", out_ovf8, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
